// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared types and constants for the boot-time program loader.
//   state_e  - loader FSM states
//   HDR_WD   - width of the length header that precedes the program
//   bytes_of - bytes per instruction word for a given word width
package inst_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_e;

  localparam int HDR_WD      = 16;
  localparam int DATA_WD_DEF = 32;

  function automatic int bytes_of(input int wd);
    return wd / 8;
  endfunction

  localparam int BYTES_DEF = bytes_of(DATA_WD_DEF);

endpackage

// File: rtl/inst_loader_byte_packer.sv
// inst_loader_byte_packer: assembles a byte stream into DATA_WD-bit words.
//   clk, reset - clock, async active-high reset
//   clear_i    - restart the byte count (word register keeps its contents)
//   shift_i    - shift byte_i into the low end of the word register
//   byte_i     - incoming byte
//   word_o     - word register
//   full_o     - this shift completes a word (count wraps to 0 on the same edge)
module inst_loader_byte_packer
  import inst_loader_pkg::*;
#(
  parameter int DATA_WD = DATA_WD_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic [7:0]         byte_i,
  output logic [DATA_WD-1:0] word_o,
  output logic               full_o
);

  localparam int BYTES = bytes_of(DATA_WD);
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  logic [DATA_WD-1:0] word_q, word_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  generate
    if (BYTES > 1) begin : g_shift
      assign word_d = shift_i ? {word_q[DATA_WD-9:0], byte_i} : word_q;
    end else begin : g_single
      assign word_d = shift_i ? byte_i : word_q;
    end
  endgenerate

  assign full_o = shift_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)     cnt_d = '0;
    else if (full_o) cnt_d = '0;
    else if (shift_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/inst_loader.sv
// inst_loader: boot loader feeding the instruction-memory write port.
// Reads a 16-bit length header (high byte first) then N big-endian words
// over a valid/ready byte stream and writes them to addresses 0..N-1.
//   clk, reset             - clock, async active-high reset
//   start                  - begin a load (honoured in IDLE/DONE/ERROR)
//   byte_valid/byte_data   - incoming byte stream
//   byte_ready             - byte accepted when valid & ready at rising edge
//   mem_address/write/data - instruction-memory write port
//   cpu_hold               - core stalled until a program is loaded
//   busy, done, error      - load status
//   word_count             - words written in current/last load
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int AD_WD   = 16,
  parameter int DATA_WD = DATA_WD_DEF,
  parameter int DEPTH   = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic [AD_WD-1:0]   mem_address,
  output logic               mem_write,
  output logic [DATA_WD-1:0] mem_data,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [AD_WD-1:0]   word_count
);

  localparam logic [HDR_WD-1:0] DEPTH_L = HDR_WD'(DEPTH);

  state_e              state_q, state_d;
  logic [AD_WD-1:0]    idx_q, idx_d;
  logic [AD_WD-1:0]    wc_q, wc_d;
  logic [HDR_WD-1:0]   len_q, len_d;
  logic [HDR_WD-1:0]   n_w;
  logic                accept;
  logic                pk_clear, pk_shift, pk_full;
  logic [DATA_WD-1:0]  word;

  inst_loader_byte_packer #(.DATA_WD(DATA_WD)) u_packer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (pk_clear),
    .shift_i (pk_shift),
    .byte_i  (byte_data),
    .word_o  (word),
    .full_o  (pk_full)
  );

  // all outputs decode registered state only
  assign byte_ready  = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
  assign busy        = byte_ready || (state_q == WRITE);
  assign mem_write   = (state_q == WRITE);
  assign done        = (state_q == DONE);
  assign error       = (state_q == ERROR);
  assign cpu_hold    = (state_q != DONE);
  assign mem_address = idx_q;
  assign mem_data    = word;
  assign word_count  = wc_q;

  assign accept = byte_valid && byte_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wc_d     = wc_q;
    len_d    = len_q;
    pk_clear = 1'b0;
    pk_shift = 1'b0;
    n_w      = {len_q[HDR_WD-1:8], byte_data};
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LEN_HI;
          idx_d   = '0;
          wc_d    = '0;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d[HDR_WD-1:8] = byte_data;
          state_d           = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d = n_w;
          if (n_w == '0) state_d = DONE;
          else if (n_w > DEPTH_L) state_d = ERROR;
          else begin
            pk_clear = 1'b1;
            idx_d    = '0;
            state_d  = DATA;
          end
        end
      end
      DATA: begin
        pk_shift = accept;
        if (pk_full) state_d = WRITE;
      end
      WRITE: begin
        idx_d   = idx_q + AD_WD'(1);
        wc_d    = wc_q + AD_WD'(1);
        state_d = (idx_d == AD_WD'(len_q)) ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wc_q    <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wc_q    <= wc_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic [15:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_data;
  logic        cpu_hold, busy, done, error;
  logic [15:0] word_count;

  inst_loader #(.AD_WD(16), .DATA_WD(32), .DEPTH(100)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .mem_address (mem_address),
    .mem_write   (mem_write),
    .mem_data    (mem_data),
    .cpu_hold    (cpu_hold),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_chk = 0;
  int  n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // write scoreboard
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      if (sb.size() == 0) chk("extra_write", {63'd0, mem_write}, 64'd0);
      else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", {48'd0, mem_address}, {48'd0, e.addr});
        chk("wr_data", {32'd0, mem_data}, {32'd0, e.data});
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // drive first nbytes of b; expected writes queued as each word's last byte is driven
  task automatic drive(input logic [7:0] b[$], input bit gap, input int nbytes);
    int n;
    logic [31:0] w;
    logic r;
    n = {b[0], b[1]};
    w = '0;
    r = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      if (gap && i >= 2 && ((i - 2) % 4) == 2) begin
        byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      byte_valid = 1'b1;
      byte_data  = b[i];
      if (i >= 2) begin
        w = {w[23:0], b[i]};
        if (((i - 2) % 4) == 3 && n <= 100) sb.push_back('{16'((i - 2) / 4), w});
      end
      for (int t = 0; t < 200; t++) begin
        @(negedge clk); r = byte_ready;
        @(posedge clk); #1;
        if (r) break;
      end
      if (!r) chk("byte_accept", {63'd0, r}, 64'd1);
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    for (int t = 0; t < 100; t++) begin
      if (done || error) break;
      @(posedge clk); #1;
    end
    chk("load_end", {63'd0, done | error}, 64'd1);
  endtask

  logic [7:0] prog2[$] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [7:0] empty[$] = '{8'h00, 8'h00};
  logic [7:0] over[$]  = '{8'h00, 8'h65};
  logic [7:0] prog1[$] = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
  logic [7:0] prog3[$] = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                           8'h99, 8'hAA, 8'hBB, 8'hCC};

  initial begin
    int cyc;
    // reset
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_hold",  {63'd0, cpu_hold}, 64'd1);
    chk("rst_ready", {63'd0, byte_ready}, 64'd0);
    chk("rst_write", {63'd0, mem_write}, 64'd0);
    chk("rst_done",  {63'd0, done}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_wc",    {48'd0, word_count}, 64'd0);
    chk("rst_addr",  {48'd0, mem_address}, 64'd0);
    chk("rst_data",  {32'd0, mem_data}, 64'd0);

    // back-to-back, full rate timing
    do_start();
    cyc = 0;
    fork
      drive(prog2, 1'b0, prog2.size());
      begin
        for (int t = 0; t < 60; t++) begin
          @(posedge clk); #1;
          cyc++;
          if (done) break;
        end
      end
    join
    chk("b2b_cycles", 64'(cyc), 64'd12);
    chk("b2b_done",   {63'd0, done}, 64'd1);
    chk("b2b_hold",   {63'd0, cpu_hold}, 64'd0);
    chk("b2b_wc",     {48'd0, word_count}, 64'd2);

    // gapped stream
    do_start();
    @(negedge clk);
    chk("restart_done_clr", {63'd0, done}, 64'd0);
    chk("restart_wc_clr",   {48'd0, word_count}, 64'd0);
    @(posedge clk); #1;
    drive(prog2, 1'b1, prog2.size());
    wait_end();
    chk("gap_done", {63'd0, done}, 64'd1);
    chk("gap_wc",   {48'd0, word_count}, 64'd2);

    // empty program
    do_start();
    drive(empty, 1'b0, 2);
    wait_end();
    chk("empty_done", {63'd0, done}, 64'd1);
    chk("empty_wc",   {48'd0, word_count}, 64'd0);
    chk("empty_hold", {63'd0, cpu_hold}, 64'd0);

    // oversize header
    do_start();
    drive(over, 1'b0, 2);
    wait_end();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("over_error", {63'd0, error}, 64'd1);
    chk("over_ready", {63'd0, byte_ready}, 64'd0);
    chk("over_hold",  {63'd0, cpu_hold}, 64'd1);
    chk("over_done",  {63'd0, done}, 64'd0);
    chk("over_wc",    {48'd0, word_count}, 64'd0);

    // fresh header after error
    do_start();
    drive(prog1, 1'b0, prog1.size());
    wait_end();
    chk("after_err_done",  {63'd0, done}, 64'd1);
    chk("after_err_error", {63'd0, error}, 64'd0);
    chk("after_err_wc",    {48'd0, word_count}, 64'd1);

    // reset after 2 bytes of the second word
    do_start();
    drive(prog3, 1'b0, 8);
    reset = 1'b1;
    #1;
    chk("abort_busy",  {63'd0, busy}, 64'd0);
    chk("abort_ready", {63'd0, byte_ready}, 64'd0);
    chk("abort_hold",  {63'd0, cpu_hold}, 64'd1);
    chk("abort_wc",    {48'd0, word_count}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_idle_write", {63'd0, mem_write}, 64'd0);

    // full load after abort restarts at address 0
    do_start();
    drive(prog1, 1'b0, prog1.size());
    wait_end();
    chk("reload_done", {63'd0, done}, 64'd1);
    chk("reload_wc",   {48'd0, word_count}, 64'd1);

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
